// File: rtl/difftest_axis_frame_checker_if.sv
// AXI-Stream beat bundle shared by the frame checker's upstream and downstream ports.
interface difftest_axis_frame_checker_if #(
    parameter int AXIS_DATA_WIDTH = 512
);
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic                         tlast;
    logic                         tvalid;
    logic                         tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/difftest_axis_frame_checker.sv
// Pass-through AXIS frame checker: FWFT FIFO decoupling DMA backpressure, plus
// per-frame sequence-byte / beat-count checking with host-visible debug counters.
module difftest_axis_frame_checker #(
    parameter int DATA_WIDTH             = 16000,
    parameter int AXIS_DATA_WIDTH        = 512,
    parameter int NUM_PACKETS_PER_BUFFER = 8,
    parameter int FIFO_DEPTH             = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    difftest_axis_frame_checker_if.slave  s_axis,
    difftest_axis_frame_checker_if.master m_axis,
    input  logic                          clear_counters,
    output logic [31:0]                   frame_count,
    output logic [15:0]                   seq_err_count,
    output logic [15:0]                   len_err_count,
    output logic                          err_sticky,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int KEEP_W        = AXIS_DATA_WIDTH / 8;
    localparam int BEATS_PER_PKT = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int FRAME_BEATS   = NUM_PACKETS_PER_BUFFER * BEATS_PER_PKT;
    localparam int PTR_W         = $clog2(FIFO_DEPTH);
    localparam int BEAT_W        = $clog2(FRAME_BEATS + 1);
    localparam int ENTRY_W       = AXIS_DATA_WIDTH + KEEP_W + 1;

    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [PTR_W:0]    FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        WAIT_SOF,
        IN_FRAME
    } state_t;

    // ---------------- FIFO ----------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     level;
    logic               ready_en;
    logic               accept;
    logic               emit;

    assign accept = s_axis.tvalid & s_axis.tready;
    assign emit   = m_axis.tvalid & m_axis.tready;

    // ready_en keeps tready low while reset is held, independent of the empty level
    assign s_axis.tready = ready_en & (level != FULL_LVL);
    assign m_axis.tvalid = (level != '0);
    assign fifo_level    = level;

    assign head = mem[rd_ptr];
    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = m_axis.tvalid ? head : '0;

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (emit)   rd_ptr <= rd_ptr + 1'b1;
            case ({accept, emit})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ---------------- Checker FSM ----------------
    state_t            state;
    state_t            state_next;
    logic [7:0]        exp_seq;
    logic [7:0]        exp_seq_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_cnt_next;
    logic              frame_hit;
    logic              seq_hit;
    logic              len_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_SOF;
            exp_seq  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            exp_seq  <= exp_seq_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // A frame ends on tlast or on the forced boundary after FRAME_BEATS beats
    always_comb begin
        state_next = state;
        if (accept) begin
            if (s_axis.tlast || (beat_cnt == LAST_IDX)) begin
                state_next = WAIT_SOF;
            end else begin
                state_next = IN_FRAME;
            end
        end
    end

    // beat_cnt is 0 exactly in WAIT_SOF, so one set of length rules covers both states
    always_comb begin
        frame_hit     = 1'b0;
        seq_hit       = 1'b0;
        len_hit       = 1'b0;
        exp_seq_next  = exp_seq;
        beat_cnt_next = beat_cnt;
        if (accept) begin
            if (state == WAIT_SOF) begin
                if (s_axis.tdata[7:0] == exp_seq) begin
                    exp_seq_next = exp_seq + 8'd1;
                end else begin
                    seq_hit      = 1'b1;
                    exp_seq_next = s_axis.tdata[7:0] + 8'd1;
                end
            end
            if (s_axis.tlast) begin
                frame_hit     = 1'b1;
                len_hit       = (beat_cnt != LAST_IDX);
                beat_cnt_next = '0;
            end else if (beat_cnt == LAST_IDX) begin
                len_hit       = 1'b1;
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_cnt + 1'b1;
            end
        end
    end

    // ---------------- Counters ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count   <= '0;
            seq_err_count <= '0;
            len_err_count <= '0;
            err_sticky    <= 1'b0;
        end else if (clear_counters) begin
            frame_count   <= '0;
            seq_err_count <= '0;
            len_err_count <= '0;
            err_sticky    <= 1'b0;
        end else begin
            if (frame_hit) frame_count <= frame_count + 1'b1;
            if (seq_hit && (seq_err_count != '1)) seq_err_count <= seq_err_count + 1'b1;
            if (len_hit && (len_err_count != '1)) len_err_count <= len_err_count + 1'b1;
            if (seq_hit || len_hit) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_difftest_axis_frame_checker.sv
// Directed scoreboard bench for difftest_axis_frame_checker (FRAME_BEATS=4, FIFO_DEPTH=4).
module tb_difftest_axis_frame_checker;

    localparam int AW = 512;
    localparam int KW = AW / 8;

    typedef logic [AW+KW:0] beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear_counters = 1'b0;
    logic [31:0] frame_count;
    logic [15:0] seq_err_count;
    logic [15:0] len_err_count;
    logic        err_sticky;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int beats_out = 0;
    beat_t sb[$];

    difftest_axis_frame_checker_if #(.AXIS_DATA_WIDTH(AW)) s_if ();
    difftest_axis_frame_checker_if #(.AXIS_DATA_WIDTH(AW)) m_if ();

    difftest_axis_frame_checker #(
        .DATA_WIDTH(1016),
        .AXIS_DATA_WIDTH(AW),
        .NUM_PACKETS_PER_BUFFER(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_axis(s_if.slave),
        .m_axis(m_if.master),
        .clear_counters(clear_counters),
        .frame_count(frame_count),
        .seq_err_count(seq_err_count),
        .len_err_count(len_err_count),
        .err_sticky(err_sticky),
        .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input beat_t obs, input beat_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: a beat handshaken at the next edge must match the scoreboard head
    always @(negedge clock) begin
        if (reset && m_if.tvalid && m_if.tready) begin
            beats_out++;
            check("out_beat_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                check_beat("out_beat", {m_if.tlast, m_if.tkeep, m_if.tdata}, sb.pop_front());
            end
        end
    end

    function automatic logic [AW-1:0] mk_data(input logic [7:0] seq);
        logic [AW-1:0] d;
        d = {16{$urandom}};
        d[7:0] = seq;
        return d;
    endfunction

    task automatic send_beat(input logic [AW-1:0] d, input logic last);
        logic [KW-1:0] k;
        logic got;
        k = {$urandom, $urandom};
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (s_if.tready) begin
                sb.push_back({last, k, d});
                got = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        if (!got) check("send_timeout", 64'(got), 64'd1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seq, input int unsigned nbeats);
        for (int unsigned b = 0; b < nbeats; b++) begin
            send_beat((b == 0) ? mk_data(seq) : mk_data(8'($urandom)), b == nbeats - 1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && fifo_level == 0) break;
        end
        check("drain_sb", 64'(sb.size()), 64'd0);
        check("drain_level", 64'(fifo_level), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        clear_counters = 1'b0;
        repeat (2) @(negedge clock);
        sb.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic check_counters(input string tag, input int unsigned fc,
                                  input int unsigned se, input int unsigned le, input logic st);
        check({tag, "_frame_count"}, 64'(frame_count), 64'(fc));
        check({tag, "_seq_err"}, 64'(seq_err_count), 64'(se));
        check({tag, "_len_err"}, 64'(len_err_count), 64'(le));
        check({tag, "_sticky"}, 64'(err_sticky), 64'(st));
    endtask

    logic [AW-1:0] d_first;
    int            out_base;

    initial begin
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        #23;
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_if.tdata[63:0]), 64'd0);
        check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check_counters("rst", 0, 0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        check("rel_s_tready_pre", 64'(s_if.tready), 64'd0);
        @(posedge clock);
        #1;
        check("rel_s_tready_post", 64'(s_if.tready), 64'd1);

        // Smoke: 3 frames, seq 0..2, first-beat latency of one cycle
        m_if.tready = 1'b1;
        d_first = mk_data(8'd0);
        send_beat(d_first, 1'b0);
        check("lat_m_tvalid", 64'(m_if.tvalid), 64'd1);
        check("lat_m_tdata", m_if.tdata[63:0], d_first[63:0]);
        check("lat_level", 64'(fifo_level), 64'd1);
        for (int unsigned b = 1; b < 4; b++) send_beat(mk_data(8'($urandom)), b == 3);
        send_frame(8'd1, 4);
        send_frame(8'd2, 4);
        wait_drain();
        check_counters("smoke", 3, 0, 0, 1'b0);

        // Backpressure: fill FIFO, hold outputs, then release
        do_reset();
        m_if.tready = 1'b0;
        out_base = beats_out;
        d_first = mk_data(8'd0);
        send_beat(d_first, 1'b0);
        for (int unsigned b = 1; b < 4; b++) send_beat(mk_data(8'($urandom)), b == 3);
        check("bp_level_full", 64'(fifo_level), 64'd4);
        s_if.tdata  = mk_data(8'd1);
        s_if.tvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("bp_s_tready", 64'(s_if.tready), 64'd0);
            check("bp_hold_tvalid", 64'(m_if.tvalid), 64'd1);
            check("bp_hold_tdata", m_if.tdata[63:0], d_first[63:0]);
        end
        @(posedge clock);
        #1;
        m_if.tready = 1'b1;
        send_beat(mk_data(8'd1), 1'b0);
        for (int unsigned b = 1; b < 4; b++) send_beat(mk_data(8'($urandom)), b == 3);
        wait_drain();
        check("bp_beats_out", 64'(beats_out - out_base), 64'd8);
        check_counters("bp", 2, 0, 0, 1'b0);

        // Sequence error: seq 0,1,5,6
        do_reset();
        send_frame(8'd0, 4);
        send_frame(8'd1, 4);
        check_counters("seq_ok", 2, 0, 0, 1'b0);
        send_frame(8'd5, 4);
        check("seq_err_on5", 64'(seq_err_count), 64'd1);
        check("seq_sticky_on5", 64'(err_sticky), 64'd1);
        send_frame(8'd6, 4);
        wait_drain();
        check_counters("seq_end", 4, 1, 0, 1'b1);

        // Length errors: 3-beat short frame, then 5-beat frame (forced boundary after 4)
        do_reset();
        send_frame(8'd0, 3);
        check_counters("short", 1, 0, 1, 1'b1);
        send_beat(mk_data(8'd1), 1'b0);
        for (int unsigned b = 1; b < 4; b++) send_beat(mk_data(8'($urandom)), 1'b0);
        check_counters("long", 1, 0, 2, 1'b1);
        // Beat 5 is re-checked as a SOF: seq 2 matches, tlast in WAIT_SOF is a length error
        send_beat(mk_data(8'd2), 1'b1);
        wait_drain();
        check_counters("len_end", 2, 0, 3, 1'b1);

        // Saturation: 65536 single-beat frames, each with a mismatched seq byte
        do_reset();
        for (int i = 0; i < 65536; i++) send_beat(mk_data(8'(2 * i + 1)), 1'b1);
        check_counters("sat", 65536, 16'hFFFF, 16'hFFFF, 1'b1);
        send_beat(mk_data(8'd1), 1'b1);
        check_counters("sat_hold", 65537, 16'hFFFF, 16'hFFFF, 1'b1);
        clear_counters = 1'b1;
        send_beat(mk_data(8'd5), 1'b1);
        clear_counters = 1'b0;
        check_counters("clear", 0, 0, 0, 1'b0);
        wait_drain();

        // Async reset mid-frame
        do_reset();
        m_if.tready = 1'b0;
        send_beat(mk_data(8'd0), 1'b0);
        send_beat(mk_data(8'($urandom)), 1'b0);
        check("mid_level", 64'(fifo_level), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clock);
        #1;
        send_frame(8'd0, 4);
        wait_drain();
        check_counters("post_rst", 1, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
